// File: rtl/hazard3_sd_dma_wb2ahb_pkg.sv
// ----------------------------------------------------------------------------
// hazard3_sd_dma_wb2ahb_pkg : AHB encodings, FSM states and sel-decode type
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hazard3_sd_dma_wb2ahb_pkg;

  localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] C_HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] C_HSIZE_HALF    = 3'd1;
  localparam logic [2:0] C_HSIZE_WORD    = 3'd2;

  localparam logic [2:0] C_HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] hsize;
    logic [1:0] addr_lo;
    logic       illegal;
  } sel_dec_t;

endpackage

`default_nettype wire

// File: rtl/hazard3_sd_dma_wb2ahb_if.sv
// ----------------------------------------------------------------------------
// hazard3_sd_dma_wb2ahb_if : Wishbone DMA port and AHB5 master port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface hazard3_sd_dma_wb2ahb_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);

  logic [W_ADDR-1:0] wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic              wb_we_i;
  logic [W_DATA-1:0] wb_dat_i;
  logic [W_DATA-1:0] wb_dat_o;
  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic [2:0]        wb_cti_i;
  logic [1:0]        wb_bte_i;
  logic              wb_ack_o;
  logic              wb_err_o;

  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic              hexcl;
  logic              hready;
  logic              hresp;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;

  modport wb_master (
    output wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport wb_slave (
    input  wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport ahb_master (
    output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
    input  hready, hresp, hrdata
  );

  modport ahb_slave (
    input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
    output hready, hresp, hrdata
  );

endinterface

`default_nettype wire

// File: rtl/hazard3_sd_wbsel_dec.sv
// ----------------------------------------------------------------------------
// hazard3_sd_wbsel_dec : Wishbone byte strobes -> AHB hsize / address low bits
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard3_sd_wbsel_dec
  import hazard3_sd_dma_wb2ahb_pkg::*;
(
  input  logic [3:0] sel,
  output sel_dec_t   dec
);

  always_comb begin
    dec = '{hsize: C_HSIZE_WORD, addr_lo: 2'b00, illegal: 1'b0};
    case (sel)
      4'b1111: dec = '{hsize: C_HSIZE_WORD, addr_lo: 2'b00, illegal: 1'b0};
      4'b0011: dec = '{hsize: C_HSIZE_HALF, addr_lo: 2'b00, illegal: 1'b0};
      4'b1100: dec = '{hsize: C_HSIZE_HALF, addr_lo: 2'b10, illegal: 1'b0};
      4'b0001: dec = '{hsize: C_HSIZE_BYTE, addr_lo: 2'b00, illegal: 1'b0};
      4'b0010: dec = '{hsize: C_HSIZE_BYTE, addr_lo: 2'b01, illegal: 1'b0};
      4'b0100: dec = '{hsize: C_HSIZE_BYTE, addr_lo: 2'b10, illegal: 1'b0};
      4'b1000: dec = '{hsize: C_HSIZE_BYTE, addr_lo: 2'b11, illegal: 1'b0};
      default: dec = '{hsize: C_HSIZE_WORD, addr_lo: 2'b00, illegal: 1'b1};
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hazard3_sd_dma_wb2ahb.sv
// ----------------------------------------------------------------------------
// hazard3_sd_dma_wb2ahb : SD DMA Wishbone master -> AHB5 SINGLE transfer bridge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard3_sd_dma_wb2ahb
  import hazard3_sd_dma_wb2ahb_pkg::*;
#(
  parameter int         W_ADDR = 32,
  parameter int         W_DATA = 32,
  parameter logic [3:0] HPROT  = 4'b0011
) (
  input  logic                               clk,
  input  logic                               rst_n,
  hazard3_sd_dma_wb2ahb_if.wb_slave          wb,
  hazard3_sd_dma_wb2ahb_if.ahb_master        ahb,
  output logic [7:0]                         err_cnt
);

  state_t            r_state,   w_state_nx;
  logic [W_ADDR-1:0] r_haddr,   w_haddr_nx;
  logic              r_hwrite,  w_hwrite_nx;
  logic [2:0]        r_hsize,   w_hsize_nx;
  logic [1:0]        r_htrans,  w_htrans_nx;
  logic [W_DATA-1:0] r_hwdata,  w_hwdata_nx;
  logic [W_DATA-1:0] r_rdata,   w_rdata_nx;
  logic              r_ack,     w_ack_nx;
  logic              r_err,     w_err_nx;
  logic              r_flag_err, w_flag_err_nx;
  logic              r_drop,    w_drop_nx;
  logic [7:0]        r_err_cnt, w_err_cnt_nx;

  sel_dec_t          w_dec;
  logic              w_req;
  logic              w_unused_ok;

  hazard3_sd_wbsel_dec u_sel_dec (
    .sel (wb.wb_sel_i),
    .dec (w_dec)
  );

  assign w_req       = wb.wb_cyc_i & wb.wb_stb_i;
  assign w_unused_ok = ^{wb.wb_cti_i, wb.wb_bte_i, wb.wb_adr_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_haddr    <= '0;
      r_hwrite   <= 1'b0;
      r_hsize    <= C_HSIZE_WORD;
      r_htrans   <= C_HTRANS_IDLE;
      r_hwdata   <= '0;
      r_rdata    <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_flag_err <= 1'b0;
      r_drop     <= 1'b0;
      r_err_cnt  <= 8'h00;
    end else begin
      r_state    <= w_state_nx;
      r_haddr    <= w_haddr_nx;
      r_hwrite   <= w_hwrite_nx;
      r_hsize    <= w_hsize_nx;
      r_htrans   <= w_htrans_nx;
      r_hwdata   <= w_hwdata_nx;
      r_rdata    <= w_rdata_nx;
      r_ack      <= w_ack_nx;
      r_err      <= w_err_nx;
      r_flag_err <= w_flag_err_nx;
      r_drop     <= w_drop_nx;
      r_err_cnt  <= w_err_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_haddr_nx    = r_haddr;
    w_hwrite_nx   = r_hwrite;
    w_hsize_nx    = r_hsize;
    w_htrans_nx   = r_htrans;
    w_hwdata_nx   = r_hwdata;
    w_rdata_nx    = r_rdata;
    w_ack_nx      = 1'b0;
    w_err_nx      = 1'b0;
    w_flag_err_nx = r_flag_err;
    w_drop_nx     = r_drop;

    case (r_state)
      ST_IDLE: begin
        // A still-high ack/err means the master has not yet seen the response
        if (w_req && !r_ack && !r_err) begin
          w_drop_nx = 1'b0;
          if (w_dec.illegal) begin
            w_flag_err_nx = 1'b1;
            w_state_nx    = ST_RESP;
          end else begin
            w_haddr_nx    = {wb.wb_adr_i[W_ADDR-1:2], w_dec.addr_lo};
            w_hwrite_nx   = wb.wb_we_i;
            w_hsize_nx    = w_dec.hsize;
            w_hwdata_nx   = wb.wb_dat_i;
            w_htrans_nx   = C_HTRANS_NONSEQ;
            w_flag_err_nx = 1'b0;
            w_state_nx    = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (!w_req) w_drop_nx = 1'b1;
        if (ahb.hready) begin
          w_htrans_nx = C_HTRANS_IDLE;
          w_state_nx  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!w_req) w_drop_nx = 1'b1;
        // First cycle of a two-cycle ERROR response has hready low; remember it
        if (ahb.hresp) w_flag_err_nx = 1'b1;
        if (ahb.hready) begin
          if (!ahb.hresp && !r_flag_err && !r_hwrite) w_rdata_nx = ahb.hrdata;
          w_state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nx = ST_IDLE;
        if (w_req && !r_drop) begin
          w_ack_nx = !r_flag_err;
          w_err_nx = r_flag_err;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase

    w_err_cnt_nx = r_err_cnt;
    if (w_err_nx && (r_err_cnt != 8'hFF)) w_err_cnt_nx = r_err_cnt + 8'd1;
  end

  assign ahb.haddr     = r_haddr;
  assign ahb.hwrite    = r_hwrite;
  assign ahb.htrans    = r_htrans;
  assign ahb.hsize     = r_hsize;
  assign ahb.hburst    = C_HBURST_SINGLE;
  assign ahb.hprot     = HPROT;
  assign ahb.hmastlock = 1'b0;
  assign ahb.hexcl     = 1'b0;
  assign ahb.hwdata    = r_hwdata;

  assign wb.wb_dat_o   = r_rdata;
  assign wb.wb_ack_o   = r_ack;
  assign wb.wb_err_o   = r_err;

  assign err_cnt       = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard3_sd_dma_wb2ahb.sv
// ----------------------------------------------------------------------------
// tb_hazard3_sd_dma_wb2ahb : self-checking bench for the SD DMA WB->AHB bridge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hazard3_sd_dma_wb2ahb;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic [31:0] rdata;
    int          aw;
    int          dw;
    logic        herr;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    logic        exp_ill;
    int          exp_lat;
  } vec_t;

  typedef struct packed {
    logic        is_err;
    logic [31:0] rdata;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] err_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int err_model = 0;
  logic [31:0] last_rd = 32'h0;
  sb_t sb_q[$];
  vec_t vecs[10];

  hazard3_sd_dma_wb2ahb_if #(.W_ADDR(32), .W_DATA(32)) bus ();

  hazard3_sd_dma_wb2ahb #(
    .W_ADDR (32),
    .W_DATA (32),
    .HPROT  (4'b0011)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb      (bus),
    .ahb     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  task automatic run_beat(input vec_t v);
    sb_t e;
    int  lat = -1;
    int  ns = 0;
    int  aw = v.aw;
    int  dw = v.dw;
    bit  in_data = 1'b0;
    bit  err_first = 1'b0;
    bit  done = 1'b0;
    bit  exp_err;
    exp_err  = v.exp_ill | v.herr;
    e.is_err = exp_err;
    e.rdata  = (!exp_err && !v.we) ? v.rdata : last_rd;
    sb_q.push_back(e);

    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    bus.wb_adr_i = v.adr; bus.wb_sel_i = v.sel;
    bus.wb_we_i  = v.we;  bus.wb_dat_i = v.dat;
    bus.hready   = 1'b1;  bus.hresp = 1'b0;

    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (bus.wb_ack_o || bus.wb_err_o) begin
        done = 1'b1;
        lat  = c;
        chk("sb_nonempty", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("ack_xor_err", {31'd0, bus.wb_ack_o ^ bus.wb_err_o}, 32'd1);
          chk("resp_is_err", {31'd0, bus.wb_err_o}, {31'd0, e.is_err});
          chk("wb_dat_o", bus.wb_dat_o, e.rdata);
          last_rd = e.rdata;
        end
        if (exp_err && err_model != 255) err_model++;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      end else if (bus.htrans == 2'b10) begin
        ns++;
        chk("haddr", bus.haddr, v.exp_haddr);
        chk("hsize", {29'd0, bus.hsize}, {29'd0, v.exp_hsize});
        chk("hwrite", {31'd0, bus.hwrite}, {31'd0, v.we});
        if (aw > 0) begin bus.hready = 1'b0; aw--; end
        else begin bus.hready = 1'b1; in_data = 1'b1; end
      end else if (in_data) begin
        if (v.we) chk("hwdata", bus.hwdata, v.dat);
        if (v.herr && !err_first) begin
          bus.hready = 1'b0; bus.hresp = 1'b1; err_first = 1'b1;
        end else if (dw > 0) begin
          bus.hready = 1'b0; bus.hresp = 1'b0; dw--;
        end else begin
          bus.hready = 1'b1; bus.hresp = v.herr; bus.hrdata = v.rdata; in_data = 1'b0;
        end
      end else begin
        bus.hready = 1'b1; bus.hresp = 1'b0;
      end
    end
    chk("beat_done", {31'd0, done}, 32'd1);
    chk("nonseq_cycles", ns, v.exp_ill ? 32'd0 : 32'(1 + v.aw));
    chk("latency", lat, v.exp_lat);
    @(negedge clk);
    bus.hready = 1'b1; bus.hresp = 1'b0;
    chk("resp_one_cycle", {30'd0, bus.wb_ack_o, bus.wb_err_o}, 32'd0);
    chk("err_cnt", {24'd0, err_cnt}, err_model);
  endtask

  initial begin
    bus.wb_adr_i = '0; bus.wb_sel_i = '0; bus.wb_we_i = 1'b0; bus.wb_dat_i = '0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cti_i = 3'b000; bus.wb_bte_i = 2'b00;
    bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;

    //             adr            sel    we    dat            rdata          aw dw herr  haddr          hsize ill  lat
    vecs[0] = '{32'h2000_0010, 4'hF, 1'b0, 32'h0000_0000, 32'hCAFE_F00D, 0, 0, 1'b0, 32'h2000_0010, 3'd2, 1'b0, 3};
    vecs[1] = '{32'h2000_0000, 4'h4, 1'b1, 32'h00AB_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h2000_0002, 3'd0, 1'b0, 3};
    vecs[2] = '{32'h2000_0010, 4'hF, 1'b0, 32'h0000_0000, 32'h1234_5678, 3, 2, 1'b0, 32'h2000_0010, 3'd2, 1'b0, 8};
    vecs[3] = '{32'h2000_0100, 4'hF, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 0, 0, 1'b1, 32'h2000_0100, 3'd2, 1'b0, 4};
    vecs[4] = '{32'h2000_0200, 4'h5, 1'b0, 32'h0000_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h0000_0000, 3'd2, 1'b1, 1};
    vecs[5] = '{32'h2000_0020, 4'hC, 1'b1, 32'h5566_0000, 32'h0000_0000, 0, 0, 1'b0, 32'h2000_0022, 3'd1, 1'b0, 3};
    vecs[6] = '{32'h2000_0033, 4'h3, 1'b0, 32'h0000_0000, 32'h0000_BEEF, 0, 0, 1'b0, 32'h2000_0030, 3'd1, 1'b0, 3};
    vecs[7] = '{32'h2000_0044, 4'h8, 1'b0, 32'h0000_0000, 32'h7700_0000, 0, 0, 1'b0, 32'h2000_0047, 3'd0, 1'b0, 3};
    vecs[8] = '{32'h2000_0050, 4'h0, 1'b1, 32'h1111_1111, 32'h0000_0000, 0, 0, 1'b0, 32'h0000_0000, 3'd2, 1'b1, 1};
    vecs[9] = '{32'h1000_0003, 4'h1, 1'b1, 32'h0000_00C3, 32'h0000_0000, 1, 1, 1'b0, 32'h1000_0000, 3'd0, 1'b0, 5};

    repeat (3) @(negedge clk);
    chk("rst_htrans", {30'd0, bus.htrans}, 32'd0);
    chk("rst_haddr", bus.haddr, 32'd0);
    chk("rst_hsize", {29'd0, bus.hsize}, 32'd2);
    chk("rst_hwrite", {31'd0, bus.hwrite}, 32'd0);
    chk("rst_hwdata", bus.hwdata, 32'd0);
    chk("rst_wb_dat_o", bus.wb_dat_o, 32'd0);
    chk("rst_ack_err", {30'd0, bus.wb_ack_o, bus.wb_err_o}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("tie_hburst", {29'd0, bus.hburst}, 32'd0);
    chk("tie_hprot", {28'd0, bus.hprot}, 32'd3);
    chk("tie_lock_excl", {30'd0, bus.hmastlock, bus.hexcl}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_beat(vecs[i]);

    // Master abandons a write during its data phase: AHB side completes, no response.
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_adr_i = 32'h2000_0300;
    bus.wb_sel_i = 4'hF; bus.wb_we_i = 1'b1; bus.wb_dat_i = 32'h1122_3344; bus.hready = 1'b1;
    @(negedge clk);
    chk("drop_nonseq", {30'd0, bus.htrans}, 32'd2);
    @(negedge clk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.hready = 1'b0;
    @(negedge clk);
    chk("drop_hwdata_held", bus.hwdata, 32'h1122_3344);
    chk("drop_htrans_idle", {30'd0, bus.htrans}, 32'd0);
    @(negedge clk);
    bus.hready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("drop_no_resp", {30'd0, bus.wb_ack_o, bus.wb_err_o}, 32'd0);
    end
    chk("drop_err_cnt", {24'd0, err_cnt}, err_model);
    run_beat(vecs[0]);

    // Drive enough illegal beats to saturate the error counter.
    for (int i = 0; i < 260; i++) run_beat(vecs[4]);
    chk("err_cnt_saturated", {24'd0, err_cnt}, 32'hFF);

    // Asynchronous reset while NONSEQ is on the bus.
    @(negedge clk);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_adr_i = 32'h2000_0400;
    bus.wb_sel_i = 4'hF; bus.wb_we_i = 1'b1; bus.wb_dat_i = 32'hA5A5_5A5A; bus.hready = 1'b0;
    @(negedge clk);
    chk("pre_rst_nonseq", {30'd0, bus.htrans}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_htrans", {30'd0, bus.htrans}, 32'd0);
    chk("arst_haddr", bus.haddr, 32'd0);
    chk("arst_hsize", {29'd0, bus.hsize}, 32'd2);
    chk("arst_hwrite", {31'd0, bus.hwrite}, 32'd0);
    chk("arst_hwdata", bus.hwdata, 32'd0);
    chk("arst_wb_dat_o", bus.wb_dat_o, 32'd0);
    chk("arst_err_cnt", {24'd0, err_cnt}, 32'd0);
    err_model = 0;
    last_rd   = 32'h0;
    sb_q.delete();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.hready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_beat(vecs[1]);
    run_beat(vecs[6]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
